ctrl_event_queue: RTL and testbench



---
 rtl/ctrl_event_queue_pkg.sv | 32 +++
 rtl/ctrl_event_queue_fifo.sv | 61 ++++++
 rtl/ctrl_event_queue.sv | 165 ++++++++++++++++
 tb/tb_ctrl_event_queue.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_event_queue_pkg.sv
// Shared definitions for the control-event queue: opcodes, response word
// layout, controller state encoding and a helper that builds the event word.
package ctrl_event_queue_pkg;

    // Read opcodes carried in aq[4:3]; 2'b11 behaves like a poll.
    localparam logic [1:0] CEQ_POLL     = 2'b00;
    localparam logic [1:0] CEQ_WAIT     = 2'b01;
    localparam logic [1:0] CEQ_COUNT    = 2'b10;
    localparam logic [1:0] CEQ_POLL_ALT = 2'b11;

    // Response word bit positions.
    localparam int RESP_VALID = 31;
    localparam int RESP_OVF   = 30;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_RESP  = 2'd2,
        ST_WRITE = 2'd3
    } ceqState_t;

    // Event response: {valid, overflow, 22'b0, src[3:0], type[3:0]}.
    function automatic logic [31:0] eventWord(input logic ovf, input logic [7:0] entry);
        logic [31:0] w;
        w             = 32'b0;
        w[RESP_VALID] = 1'b1;
        w[RESP_OVF]   = ovf;
        w[7:0]        = entry;
        return w;
    endfunction

endpackage

// File: rtl/ctrl_event_queue_fifo.sv
// DEPTH x 8 register FIFO with first-word-fall-through head, async reset and
// a synchronous flush that discards everything, including a same-cycle push.
module ceq_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    pushData,
    output logic [7:0]    headData,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rdPtr;
    logic [AW-1:0] wrPtr;
    logic          doPush;
    logic          doPop;

    assign empty    = (count == '0);
    assign full     = (count == FULL_COUNT);
    // A pop frees the head slot this cycle, so a push into a full FIFO is
    // accepted when it coincides with a pop.
    assign doPop    = pop & ~empty & ~flush;
    assign doPush   = push & (~full | doPop) & ~flush;
    assign headData = mem[rdPtr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + AW'(1);
            if (doPop)  rdPtr <= rdPtr + AW'(1);
            case ({doPush, doPop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clock) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/ctrl_event_queue.sv
// Control-event queue: buffers {src,type} zero-length control messages and
// serves them to the CPU as an AQ/WQ/RQ local I/O device (poll, blocking
// wait, count query, type-mask write, flush).
//
// Bus handshake: selCtrl & aq/read/wq form a request that is only sampled in
// IDLE; the CPU holds the AQ entry stable until done. done is a single-cycle
// completion strobe: with wrq for reads (rqCtrl valid in that same cycle) and
// with rwq for writes (wq consumed in that cycle). ctrlValid is a one-cycle
// pulse with no back-pressure; it is accepted in every state.
module ctrl_event_queue
    import ctrl_event_queue_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [16:3]   aq,
    input  logic          read,
    input  logic [31:0]   wq,
    output logic          rwq,
    output logic [31:0]   rqCtrl,
    output logic          wrq,
    output logic          done,
    input  logic          selCtrl,
    input  logic          ctrlValid,
    input  logic [3:0]    ctrlType,
    input  logic [3:0]    ctrlSrc,
    output logic [1:0]    stateDbg
);

    ceqState_t   state;
    ceqState_t   nextState;
    logic [1:0]  op;
    logic [31:0] respReg;
    logic [31:0] respNext;
    logic        overflow;
    logic        overflowNext;
    logic [15:0] typeMask;
    logic        pushReq;
    logic        popReq;
    logic        flush;
    logic        newOverflow;
    logic [7:0]  headData;
    logic [AW:0] count;
    logic        full;
    logic        empty;
    logic        unusedBits;

    assign op          = aq[4:3];
    assign stateDbg    = state;
    assign pushReq     = ctrlValid & typeMask[ctrlType];
    assign flush       = (state == ST_WRITE) & aq[3];
    assign newOverflow = pushReq & full & ~popReq & ~flush;
    assign unusedBits  = ^{aq[16:5], wq[31:16]};

    ceq_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .flush    (flush),
        .push     (pushReq),
        .pop      (popReq),
        .pushData ({ctrlSrc, ctrlType}),
        .headData (headData),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    // Controller state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= nextState;
    end

    // Next state, pop decision, response capture and bus strobes.
    always_comb begin
        nextState = state;
        popReq    = 1'b0;
        respNext  = respReg;
        rwq       = 1'b0;
        wrq       = 1'b0;
        done      = 1'b0;
        rqCtrl    = 32'b0;
        case (state)
            ST_IDLE: begin
                if (selCtrl) begin
                    if (read) begin
                        case (op)
                            CEQ_COUNT: begin
                                respNext  = {overflow, 31'(count)};
                                nextState = ST_RESP;
                            end
                            CEQ_WAIT: begin
                                if (!empty) begin
                                    popReq    = 1'b1;
                                    respNext  = eventWord(overflow, headData);
                                    nextState = ST_RESP;
                                end else begin
                                    nextState = ST_WAIT;
                                end
                            end
                            default: begin
                                nextState = ST_RESP;
                                if (!empty) begin
                                    popReq   = 1'b1;
                                    respNext = eventWord(overflow, headData);
                                end else begin
                                    respNext = 32'b0;
                                end
                            end
                        endcase
                    end else begin
                        nextState = ST_WRITE;
                    end
                end
            end
            ST_WAIT: begin
                if (!empty) begin
                    popReq    = 1'b1;
                    respNext  = eventWord(overflow, headData);
                    nextState = ST_RESP;
                end
            end
            ST_RESP: begin
                wrq       = 1'b1;
                done      = 1'b1;
                rqCtrl    = respReg;
                nextState = ST_IDLE;
            end
            ST_WRITE: begin
                rwq       = 1'b1;
                done      = 1'b1;
                nextState = ST_IDLE;
            end
            default: nextState = ST_IDLE;
        endcase
    end

    // Sticky overflow: flush clears, a fresh overflow beats the clear that
    // returning an event would otherwise cause.
    always_comb begin
        overflowNext = overflow;
        if (flush)            overflowNext = 1'b0;
        else if (newOverflow) overflowNext = 1'b1;
        else if (popReq)      overflowNext = 1'b0;
    end

    // Response, overflow and type-mask registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            respReg  <= 32'b0;
            overflow <= 1'b0;
            typeMask <= 16'hFFFF;
        end else begin
            respReg  <= respNext;
            overflow <= overflowNext;
            if ((state == ST_WRITE) && !aq[3]) typeMask <= wq[15:0];
        end
    end

endmodule

// File: tb/tb_ctrl_event_queue.sv
// Directed bench for ctrl_event_queue with a transaction-level reference
// model (event queue + sticky overflow + mask) checked every cycle, plus
// literal expectations for the documented scenarios.
module tb_ctrl_event_queue;

  localparam int DEPTH = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [16:3] aq;
  logic        read;
  logic [31:0] wq;
  logic        rwq;
  logic [31:0] rqCtrl;
  logic        wrq;
  logic        done;
  logic        selCtrl;
  logic        ctrlValid;
  logic [3:0]  ctrlType;
  logic [3:0]  ctrlSrc;
  logic [1:0]  stateDbg;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  ctrl_event_queue #(.DEPTH(DEPTH), .AW(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .aq        (aq),
    .read      (read),
    .wq        (wq),
    .rwq       (rwq),
    .rqCtrl    (rqCtrl),
    .wrq       (wrq),
    .done      (done),
    .selCtrl   (selCtrl),
    .ctrlValid (ctrlValid),
    .ctrlType  (ctrlType),
    .ctrlSrc   (ctrlSrc),
    .stateDbg  (stateDbg)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 waiting for an event, 2 responding, 3 writing
  logic [7:0]  exp_q[$];
  logic        m_ovf;
  logic [15:0] m_mask;
  int          m_phase;
  logic [31:0] m_word;
  logic        exp_done, exp_wrq, exp_rwq;
  logic [31:0] exp_rq;
  logic [1:0]  exp_state;

  task automatic model_outputs();
    exp_done  = (m_phase == 2) || (m_phase == 3);
    exp_wrq   = (m_phase == 2);
    exp_rwq   = (m_phase == 3);
    exp_rq    = (m_phase == 2) ? m_word : 32'b0;
    exp_state = 2'(m_phase);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ovf   = 1'b0;
    m_mask  = 16'hFFFF;
    m_phase = 0;
    m_word  = 32'b0;
    model_outputs();
  endtask

  // One clock edge worth of device behaviour, from the current inputs.
  task automatic model_tick();
    int          next_phase;
    bit          popped;
    bit          do_flush;
    bit          new_ovf;
    logic [15:0] mask_next;
    logic [7:0]  head;
    if (reset) return;
    next_phase = 0;
    popped     = 0;
    do_flush   = 0;
    new_ovf    = 0;
    mask_next  = m_mask;
    case (m_phase)
      0: if (selCtrl) begin
           if (read) begin
             if (aq[4:3] == 2'b10) begin
               m_word = {m_ovf, 31'(exp_q.size())};
               next_phase = 2;
             end else if (exp_q.size() > 0) begin
               head = exp_q.pop_front();
               m_word = {1'b1, m_ovf, 22'b0, head};
               popped = 1;
               next_phase = 2;
             end else if (aq[4:3] == 2'b01) begin
               next_phase = 1;
             end else begin
               m_word = 32'b0;
               next_phase = 2;
             end
           end else begin
             next_phase = 3;
           end
         end
      1: if (exp_q.size() > 0) begin
           head = exp_q.pop_front();
           m_word = {1'b1, m_ovf, 22'b0, head};
           popped = 1;
           next_phase = 2;
         end else begin
           next_phase = 1;
         end
      3: if (aq[3]) do_flush = 1;
         else mask_next = wq[15:0];
      default: next_phase = 0;
    endcase
    if (do_flush) begin
      exp_q.delete();
      m_ovf = 1'b0;
    end else begin
      if (ctrlValid && m_mask[ctrlType]) begin
        if (exp_q.size() < DEPTH) exp_q.push_back({ctrlSrc, ctrlType});
        else new_ovf = 1;
      end
      if (new_ovf) m_ovf = 1'b1;
      else if (popped) m_ovf = 1'b0;
    end
    m_mask  = mask_next;
    m_phase = next_phase;
    model_outputs();
  endtask

  // ---------------- scoreboard compare ----------------
  always @(negedge clock) begin
    #1;
    check("done", {31'b0, done}, {31'b0, exp_done});
    check("wrq", {31'b0, wrq}, {31'b0, exp_wrq});
    check("rwq", {31'b0, rwq}, {31'b0, exp_rwq});
    check("rqCtrl", rqCtrl, exp_rq);
    check("state", {30'b0, stateDbg}, {30'b0, exp_state});
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clock);
    model_tick();
    @(negedge clock);
  endtask

  task automatic ev(input logic [3:0] src, input logic [3:0] typ);
    ctrlValid = 1'b1;
    ctrlSrc   = src;
    ctrlType  = typ;
    cyc();
    ctrlValid = 1'b0;
  endtask

  // Issue one bus request, hold it until done, then release it.
  // evFirst: event on the edge that registers the request.
  // evLate:  event on the edge that ends the RESP/WRITE cycle.
  task automatic req(input logic is_read, input logic [1:0] op, input logic [31:0] wdata,
                     input bit ev_first, input bit ev_late,
                     input logic [3:0] src, input logic [3:0] typ,
                     output logic [31:0] word, output int lat);
    aq        = '0;
    aq[4:3]   = op;
    read      = is_read;
    wq        = wdata;
    selCtrl   = 1'b1;
    ctrlValid = ev_first;
    ctrlSrc   = src;
    ctrlType  = typ;
    word      = 32'b0;
    lat       = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      ctrlValid = 1'b0;
      lat++;
      if (done) begin
        word = rqCtrl;
        break;
      end
    end
    check("req_done", {31'b0, done}, 32'd1);
    selCtrl   = 1'b0;
    ctrlValid = ev_late;
    cyc();
    ctrlValid = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [31:0] w;
    int          lat;
    int          n;
    bit          saw_done;

    aq = '0; read = 1'b0; wq = '0; selCtrl = 1'b0;
    ctrlValid = 1'b0; ctrlType = '0; ctrlSrc = '0;
    reset = 1'b1;
    model_reset();
    cyc();
    cyc();
    check("rst_rq", rqCtrl, 32'h0);
    check("rst_done", {29'b0, done, wrq, rwq}, 32'h0);
    check("rst_state", {30'b0, stateDbg}, 32'h0);
    reset = 1'b0;
    cyc();

    // single event then two polls
    ev(4'd3, 4'd5);
    req(1'b1, 2'b00, 32'h0, 0, 0, 4'd0, 4'd0, w, lat);
    check("poll1_word", w, 32'h8000_0035);
    check("poll1_lat", 32'(lat), 32'd1);
    req(1'b1, 2'b00, 32'h0, 0, 0, 4'd0, 4'd0, w, lat);
    check("poll2_empty", w, 32'h0);

    // blocking wait on an empty queue
    aq = '0; aq[4:3] = 2'b01; read = 1'b1; selCtrl = 1'b1;
    saw_done = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (done) saw_done = 1;
    end
    check("wait_no_done", {31'b0, saw_done}, 32'd0);
    ctrlSrc = 4'd7; ctrlType = 4'd2; ctrlValid = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      ctrlValid = 1'b0;
      n++;
      if (done) break;
    end
    check("wait_done", {31'b0, done}, 32'd1);
    check("wait_word", rqCtrl, 32'h8000_0072);
    check("wait_lat", 32'(n), 32'd2);
    selCtrl = 1'b0;
    cyc();

    // overflow: 17 pushes into a 16-deep queue
    for (int i = 0; i < 17; i++) ev(4'(i), 4'(15 - i));
    req(1'b1, 2'b10, 32'h0, 0, 0, 4'd0, 4'd0, w, lat);
    check("count_ovf", w, 32'h8000_0010);
    req(1'b1, 2'b00, 32'h0, 0, 0, 4'd0, 4'd0, w, lat);
    check("poll_ovf_set", w, 32'hC000_000F);
    req(1'b1, 2'b00, 32'h0, 0, 0, 4'd0, 4'd0, w, lat);
    check("poll_ovf_clr", w, 32'h8000_001E);

    // refill to full, then pop and push in the same cycle
    ev(4'hB, 4'h1);
    ev(4'hC, 4'h2);
    req(1'b1, 2'b00, 32'h0, 1, 0, 4'hA, 4'h6, w, lat);
    check("full_poll", w, 32'h8000_002D);
    req(1'b1, 2'b10, 32'h0, 0, 0, 4'd0, 4'd0, w, lat);
    check("full_count", w, 32'h0000_0010);
    for (int i = 0; i < 15; i++) req(1'b1, 2'b11, 32'h0, 0, 0, 4'd0, 4'd0, w, lat);
    req(1'b1, 2'b00, 32'h0, 0, 0, 4'd0, 4'd0, w, lat);
    check("full_order_last", w, 32'h8000_00A6);

    // type mask
    req(1'b0, 2'b00, 32'h0000_0004, 0, 0, 4'd0, 4'd0, w, lat);
    check("mask_lat", 32'(lat), 32'd1);
    ev(4'd1, 4'd2);
    ev(4'd1, 4'd3);
    req(1'b1, 2'b10, 32'h0, 0, 0, 4'd0, 4'd0, w, lat);
    check("mask_count", w, 32'h0000_0001);
    req(1'b1, 2'b00, 32'h0, 0, 0, 4'd0, 4'd0, w, lat);
    check("mask_poll", w, 32'h8000_0012);
    req(1'b0, 2'b00, 32'h0000_FFFF, 0, 0, 4'd0, 4'd0, w, lat);

    // reset while waiting
    aq = '0; aq[4:3] = 2'b01; read = 1'b1; selCtrl = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    check("rstwait_state", {30'b0, stateDbg}, 32'd1);
    reset = 1'b1;
    model_reset();
    #1;
    check("rstwait_idle", {30'b0, stateDbg}, 32'd0);
    check("rstwait_done", {31'b0, done}, 32'd0);
    selCtrl = 1'b0;
    cyc();
    reset = 1'b0;
    cyc();

    // flush with a coincident event
    ev(4'd4, 4'd4);
    ev(4'd5, 4'd5);
    req(1'b0, 2'b01, 32'h0, 0, 1, 4'd9, 4'd9, w, lat);
    req(1'b1, 2'b10, 32'h0, 0, 0, 4'd0, 4'd0, w, lat);
    check("flush_count", w, 32'h0);

    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
